// File: rtl/volt_scan_meter.sv
// Multi-channel scanning voltmeter: drives the ADC clock and mux select, averages
// each channel, converts to signed millivolts and keeps live and peak results.
module volt_scan_meter #(
  parameter int AD_WIDTH = 8,
  parameter int CH_NUM   = 4,
  parameter int AVG_LOG2 = 2,
  parameter int DISCARD  = 1,
  parameter int DIV_HALF = 1,
  parameter int FS_MV    = 5000,
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [AD_WIDTH-1:0] ad_data,
  input  logic                mode,
  input  logic                hold_clr,
  input  logic [CH_W-1:0]     disp_ch,
  output logic                ad_clk,
  output logic [CH_W-1:0]     ad_ch,
  output logic                volt_valid,
  output logic [CH_W-1:0]     res_ch,
  output logic [19:0]         res_data,
  output logic                res_sign,
  output logic [19:0]         disp_data,
  output logic                disp_sign
);

  localparam int NAVG   = 1 << AVG_LOG2;
  localparam int ACC_W  = AD_WIDTH + AVG_LOG2;
  localparam int DIV_W  = $clog2(2 * DIV_HALF);
  localparam int CNT_W  = 7;
  localparam int PROD_W = AD_WIDTH + 17;
  localparam int CH_SZ  = 1 << CH_W;

  localparam logic [AD_WIDTH-1:0] MID       = {1'b1, {(AD_WIDTH-1){1'b0}}};
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(2 * DIV_HALF - 1);
  localparam logic [DIV_W-1:0]    DIV_ON    = DIV_W'(DIV_HALF);
  localparam logic [CNT_W-1:0]    AVG_LAST  = CNT_W'(NAVG - 1);
  localparam logic [CNT_W-1:0]    DISC_LAST = CNT_W'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam logic [CH_W-1:0]     CH_LAST   = CH_W'(CH_NUM - 1);
  localparam logic                NO_SETTLE = (DISCARD == 0);

  typedef enum logic [0:0] {SETTLE = 1'b0, ACCUM = 1'b1} state_t;

  logic [DIV_W-1:0]    div_cnt_r, div_nxt_s;
  logic                strobe_s, ad_clk_r;
  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [ACC_W-1:0]    acc_r, acc_sum_s;
  logic [CH_W-1:0]     ad_ch_r;
  logic                take_s, last_s;
  logic [AD_WIDTH-1:0] avg_s, calc_avg_r;
  logic [CH_W-1:0]     calc_ch_r;
  logic                calc_vld_r;

  logic                s1_sign_s;
  logic [AD_WIDTH-1:0] s1_mag_s;
  logic [PROD_W-1:0]   s1_prod_s;
  logic [19:0]         s1_mv_s;
  logic                s1_vld_r, s1_sign_r;
  logic [19:0]         s1_mv_r;
  logic [CH_W-1:0]     s1_ch_r;

  logic [CH_SZ-1:0][20:0] live_r, peak_r;
  logic [20:0]         pk_base_s, pk_new_s, live_new_s, res_sel_s, disp_sel_s;
  logic                volt_valid_r, res_sign_r, disp_sign_r;
  logic [CH_W-1:0]     res_ch_r;
  logic [19:0]         res_data_r, disp_data_r;

  // Sample-clock divider next state and strobe decode
  always_comb begin
    strobe_s = (div_cnt_r == DIV_LAST);
    if (strobe_s) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else begin
      div_nxt_s = div_cnt_r + DIV_W'(1);
    end
  end

  // Free-running divider and registered ADC clock
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      ad_clk_r  <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      ad_clk_r  <= (div_nxt_s >= DIV_ON);
    end
  end

  // Accumulate decode; with no settling samples every strobe is an accumulate strobe
  always_comb begin
    acc_sum_s = acc_r + ACC_W'(ad_data);
    take_s    = strobe_s && ((state_r == ACCUM) || NO_SETTLE);
    last_s    = take_s && (cnt_r == AVG_LAST);
    avg_s     = AD_WIDTH'(acc_sum_s >> AVG_LOG2);
  end

  // Channel FSM: discard settling samples, accumulate, hand off average, advance mux
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r    <= SETTLE;
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      ad_ch_r    <= {CH_W{1'b0}};
      calc_avg_r <= {AD_WIDTH{1'b0}};
      calc_ch_r  <= {CH_W{1'b0}};
      calc_vld_r <= 1'b0;
    end else begin
      calc_vld_r <= 1'b0;
      if (take_s) begin
        if (last_s) begin
          calc_avg_r <= avg_s;
          calc_ch_r  <= ad_ch_r;
          calc_vld_r <= 1'b1;
          acc_r      <= {ACC_W{1'b0}};
          cnt_r      <= {CNT_W{1'b0}};
          ad_ch_r    <= (ad_ch_r == CH_LAST) ? {CH_W{1'b0}} : ad_ch_r + CH_W'(1);
          state_r    <= SETTLE;
        end else begin
          acc_r   <= acc_sum_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          state_r <= ACCUM;
        end
      end else if (strobe_s) begin
        if (cnt_r == DISC_LAST) begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= ACCUM;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  // Offset-binary to signed magnitude and scaling to millivolts
  always_comb begin
    s1_sign_s = (calc_avg_r < MID);
    if (s1_sign_s) begin
      s1_mag_s = MID - calc_avg_r;
    end else begin
      s1_mag_s = calc_avg_r - MID;
    end
    s1_prod_s = PROD_W'(s1_mag_s) * PROD_W'(FS_MV);
    s1_mv_s   = 20'(s1_prod_s >> (AD_WIDTH - 1));
  end

  // Conversion pipeline stage 1
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_vld_r  <= 1'b0;
      s1_sign_r <= 1'b0;
      s1_mv_r   <= 20'd0;
      s1_ch_r   <= {CH_W{1'b0}};
    end else begin
      s1_vld_r  <= calc_vld_r;
      s1_sign_r <= s1_sign_s;
      s1_mv_r   <= s1_mv_s;
      s1_ch_r   <= calc_ch_r;
    end
  end

  // Peak update compares against zero when a clear lands in the same cycle
  always_comb begin
    live_new_s = {s1_sign_r, s1_mv_r};
    if (hold_clr) begin
      pk_base_s = 21'd0;
    end else begin
      pk_base_s = peak_r[s1_ch_r];
    end
    if (s1_mv_r > pk_base_s[19:0]) begin
      pk_new_s = live_new_s;
    end else begin
      pk_new_s = pk_base_s;
    end
    if (mode) begin
      res_sel_s  = pk_new_s;
      disp_sel_s = peak_r[disp_ch];
    end else begin
      res_sel_s  = live_new_s;
      disp_sel_s = live_r[disp_ch];
    end
  end

  // Stage 2: result registers, live/peak store and result outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      live_r       <= {(CH_SZ*21){1'b0}};
      peak_r       <= {(CH_SZ*21){1'b0}};
      volt_valid_r <= 1'b0;
      res_ch_r     <= {CH_W{1'b0}};
      res_data_r   <= 20'd0;
      res_sign_r   <= 1'b0;
    end else begin
      volt_valid_r <= s1_vld_r;
      if (hold_clr) begin
        peak_r <= {(CH_SZ*21){1'b0}};
      end
      if (s1_vld_r) begin
        live_r[s1_ch_r] <= live_new_s;
        peak_r[s1_ch_r] <= pk_new_s;
        res_ch_r        <= s1_ch_r;
        res_data_r      <= res_sel_s[19:0];
        res_sign_r      <= res_sel_s[20];
      end
    end
  end

  // Display port register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      disp_data_r <= 20'd0;
      disp_sign_r <= 1'b0;
    end else begin
      disp_data_r <= disp_sel_s[19:0];
      disp_sign_r <= disp_sel_s[20];
    end
  end

  assign ad_clk     = ad_clk_r;
  assign ad_ch      = ad_ch_r;
  assign volt_valid = volt_valid_r;
  assign res_ch     = res_ch_r;
  assign res_data   = res_data_r;
  assign res_sign   = res_sign_r;
  assign disp_data  = disp_data_r;
  assign disp_sign  = disp_sign_r;

endmodule

// File: tb/tb_volt_scan_meter.sv
// Self-checking bench for volt_scan_meter (default parameters): directed scenarios
// plus a randomized scan checked against a per-scan arithmetic reference model.
module tb_volt_scan_meter;

  localparam int MID   = 128;
  localparam int FS_MV = 5000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  ad_data = 8'd0;
  logic        mode = 1'b0;
  logic        hold_clr = 1'b0;
  logic [1:0]  disp_ch = 2'd0;
  logic        ad_clk, volt_valid, res_sign, disp_sign;
  logic [1:0]  ad_ch, res_ch;
  logic [19:0] res_data, disp_data;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;
  int samp [512];

  volt_scan_meter dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ad_data(ad_data), .mode(mode),
    .hold_clr(hold_clr), .disp_ch(disp_ch), .ad_clk(ad_clk), .ad_ch(ad_ch),
    .volt_valid(volt_valid), .res_ch(res_ch), .res_data(res_data),
    .res_sign(res_sign), .disp_data(disp_data), .disp_sign(disp_sign)
  );

  always #5 sys_clk = ~sys_clk;

  // cyc = index of the last rising edge since reset release (edge 0 is the first)
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= -1;
    else         cyc <= cyc + 1;
  end

  function automatic int exp_mv(input int code);
    int mag;
    mag = (code < MID) ? MID - code : code - MID;
    return (mag * FS_MV) / MID;
  endfunction

  function automatic int exp_neg(input int code);
    return (code < MID) ? 1 : 0;
  endfunction

  // Average of the four kept samples of scan s (five strobes per scan, first discarded)
  function automatic int scan_code(input int s);
    return (samp[5*s+1] + samp[5*s+2] + samp[5*s+3] + samp[5*s+4]) / 4;
  endfunction

  function automatic int is_valid_cyc(input int k);
    return (k >= 11 && (k - 11) % 10 == 0) ? 1 : 0;
  endfunction

  // Advance to the next falling edge and present the sample for the coming strobe
  task automatic tick();
    @(negedge sys_clk);
    ad_data = 8'(samp[((cyc < 0) ? 0 : cyc / 2) % 512]);
  endtask

  task automatic fill(input int code);
    for (int i = 0; i < 512; i++) samp[i] = code;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    hold_clr = 1'b0;
    repeat (2) @(negedge sys_clk);
    ad_data = 8'(samp[0]);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    fill(255);
    mode = 1'b0; disp_ch = 2'd0; hold_clr = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({ad_clk, ad_ch, volt_valid, res_ch, res_sign, disp_sign} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0", {ad_clk, ad_ch, volt_valid, res_ch, res_sign, disp_sign});
    end
    n_checks++;
    if ({res_data, disp_data} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_data: got res=%0d disp=%0d expected 0", res_data, disp_data);
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_constant_codes();
    int codes [3];
    int k, c, ev;
    codes[0] = 255; codes[1] = 0; codes[2] = 128;
    for (int t = 0; t < 3; t++) begin
      c = codes[t];
      fill(c);
      do_reset();
      repeat (53) begin
        tick();
        k = cyc;
        ev = is_valid_cyc(k);
        n_checks++;
        if (volt_valid !== 1'(ev)) begin
          n_fail++;
          $display("FAIL const_valid code=%0d cyc=%0d: got %b expected %0d", c, k, volt_valid, ev);
        end
        n_checks++;
        if (ad_ch !== 2'(((k + 1) / 10) % 4)) begin
          n_fail++;
          $display("FAIL ad_ch cyc=%0d: got %0d expected %0d", k, ad_ch, ((k + 1) / 10) % 4);
        end
        n_checks++;
        if (ad_clk !== 1'(k % 2 == 0)) begin
          n_fail++;
          $display("FAIL ad_clk cyc=%0d: got %b expected %0d", k, ad_clk, (k % 2 == 0));
        end
        if (ev == 1) begin
          n_checks++;
          if (res_ch !== 2'(((k - 11) / 10) % 4) || res_data !== 20'(exp_mv(c)) || res_sign !== 1'(exp_neg(c))) begin
            n_fail++;
            $display("FAIL const_result code=%0d cyc=%0d: got ch=%0d data=%0d sign=%b expected ch=%0d data=%0d sign=%0d",
                     c, k, res_ch, res_data, res_sign, ((k - 11) / 10) % 4, exp_mv(c), exp_neg(c));
          end
        end
      end
    end
  endtask

  task automatic test_random_scan();
    int lv_mag [4], lv_neg [4], pk_mag [4], pk_neg [4];
    int k, s, ch, code, m, ng, ev, e_mag, e_neg, pend_mag, pend_neg;
    logic mode_app, hc_app;
    for (int i = 0; i < 512; i++) samp[i] = int'($urandom_range(0, 255));
    samp[0] = 9; samp[1] = 100; samp[2] = 102; samp[3] = 104; samp[4] = 106;
    for (int i = 0; i < 4; i++) begin lv_mag[i] = 0; lv_neg[i] = 0; pk_mag[i] = 0; pk_neg[i] = 0; end
    mode = 1'b0; disp_ch = 2'd0;
    do_reset();
    pend_mag = 0; pend_neg = 0; mode_app = 1'b0; hc_app = 1'b0;
    repeat (200) begin
      tick();
      k = cyc;
      if (hc_app) for (int i = 0; i < 4; i++) begin pk_mag[i] = 0; pk_neg[i] = 0; end
      ev = is_valid_cyc(k);
      n_checks++;
      if (volt_valid !== 1'(ev)) begin
        n_fail++;
        $display("FAIL rand_valid cyc=%0d: got %b expected %0d", k, volt_valid, ev);
      end
      if (ev == 1) begin
        s = (k - 11) / 10;
        ch = s % 4;
        code = scan_code(s);
        m = exp_mv(code);
        ng = exp_neg(code);
        lv_mag[ch] = m; lv_neg[ch] = ng;
        if (m > pk_mag[ch]) begin pk_mag[ch] = m; pk_neg[ch] = ng; end
        e_mag = mode_app ? pk_mag[ch] : lv_mag[ch];
        e_neg = mode_app ? pk_neg[ch] : lv_neg[ch];
        n_checks++;
        if (res_ch !== 2'(ch) || res_data !== 20'(e_mag) || res_sign !== 1'(e_neg)) begin
          n_fail++;
          $display("FAIL rand_result cyc=%0d: got ch=%0d data=%0d sign=%b expected ch=%0d data=%0d sign=%0d",
                   k, res_ch, res_data, res_sign, ch, e_mag, e_neg);
        end
        if (k == 11) begin
          n_checks++;
          if (res_data !== 20'd976 || res_sign !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_discard: got data=%0d sign=%b expected data=976 sign=1", res_data, res_sign);
          end
        end
      end
      n_checks++;
      if (disp_data !== 20'(pend_mag) || disp_sign !== 1'(pend_neg)) begin
        n_fail++;
        $display("FAIL rand_disp cyc=%0d: got data=%0d sign=%b expected data=%0d sign=%0d",
                 k, disp_data, disp_sign, pend_mag, pend_neg);
      end
      mode = 1'($urandom_range(0, 1));
      disp_ch = 2'($urandom_range(0, 3));
      hold_clr = ($urandom_range(0, 7) == 0);
      mode_app = mode;
      hc_app = hold_clr;
      pend_mag = mode ? pk_mag[disp_ch] : lv_mag[disp_ch];
      pend_neg = mode ? pk_neg[disp_ch] : lv_neg[disp_ch];
    end
    hold_clr = 1'b0;
    mode = 1'b0;
  endtask

  task automatic test_peak_hold();
    int k;
    fill(128);
    for (int i = 0; i < 5; i++) begin
      samp[i] = 200; samp[20+i] = 150; samp[40+i] = 150; samp[60+i] = 140;
    end
    mode = 1'b1; disp_ch = 2'd0;
    do_reset();
    repeat (134) begin
      tick();
      k = cyc;
      if (k == 11 || k == 51 || k == 91 || k == 131) begin
        n_checks++;
        if (volt_valid !== 1'b1 || res_ch !== 2'd0) begin
          n_fail++;
          $display("FAIL peak_valid cyc=%0d: got valid=%b ch=%0d expected valid=1 ch=0", k, volt_valid, res_ch);
        end
      end
      if (k == 11 || k == 51) begin
        n_checks++;
        if (res_data !== 20'd2812 || res_sign !== 1'b0) begin
          n_fail++;
          $display("FAIL peak_hold cyc=%0d: got %0d sign=%b expected 2812 sign=0", k, res_data, res_sign);
        end
      end
      if (k == 51) mode = 1'b0;
      if (k == 52) begin
        n_checks++;
        if (disp_data !== 20'd859) begin
          n_fail++;
          $display("FAIL live_ch0: got %0d expected 859", disp_data);
        end
        mode = 1'b1;
      end
      if (k == 53) begin
        n_checks++;
        if (disp_data !== 20'd2812) begin
          n_fail++;
          $display("FAIL peak_disp: got %0d expected 2812", disp_data);
        end
      end
      hold_clr = (k == 60 || k == 130);
      if (k == 62) begin
        n_checks++;
        if (disp_data !== 20'd0 || disp_sign !== 1'b0) begin
          n_fail++;
          $display("FAIL peak_cleared: got %0d sign=%b expected 0", disp_data, disp_sign);
        end
      end
      if (k == 91) begin
        n_checks++;
        if (res_data !== 20'd859) begin
          n_fail++;
          $display("FAIL after_clear: got %0d expected 859", res_data);
        end
      end
      // code 140 -> 12 * 5000 / 128 = 468, below the 859 already held
      if (k == 131) begin
        n_checks++;
        if (res_data !== 20'd468 || res_sign !== 1'b0) begin
          n_fail++;
          $display("FAIL clr_coincident_res: got %0d sign=%b expected 468 sign=0", res_data, res_sign);
        end
      end
      if (k == 132) begin
        n_checks++;
        if (disp_data !== 20'd468) begin
          n_fail++;
          $display("FAIL clr_coincident_peak: got %0d expected 468", disp_data);
        end
      end
    end
    hold_clr = 1'b0;
    mode = 1'b0;
  endtask

  task automatic test_display();
    int k;
    int codes [4];
    codes[0] = 60; codes[1] = 90; codes[2] = 160; codes[3] = 230;
    fill(128);
    for (int s = 0; s < 4; s++) for (int j = 1; j < 5; j++) samp[5*s+j] = codes[s];
    mode = 1'b0; disp_ch = 2'd0;
    do_reset();
    repeat (75) begin
      tick();
      k = cyc;
      if (k == 45) disp_ch = 2'd2;
      if (k == 46) begin
        n_checks++;
        if (disp_data !== 20'd1250 || disp_sign !== 1'b0) begin
          n_fail++;
          $display("FAIL disp_ch2: got %0d sign=%b expected 1250 sign=0", disp_data, disp_sign);
        end
        disp_ch = 2'd3;
      end
      if (k == 47) begin
        n_checks++;
        if (disp_data !== 20'd3984 || disp_sign !== 1'b0) begin
          n_fail++;
          $display("FAIL disp_ch3: got %0d sign=%b expected 3984 sign=0", disp_data, disp_sign);
        end
        disp_ch = 2'd0;
      end
      if (k == 48) begin
        n_checks++;
        if (disp_data !== 20'd2656 || disp_sign !== 1'b1) begin
          n_fail++;
          $display("FAIL disp_ch0: got %0d sign=%b expected 2656 sign=1", disp_data, disp_sign);
        end
        disp_ch = 2'd2;
      end
      if (k == 72 || k == 74) begin
        n_checks++;
        if (disp_data !== 20'd0 || disp_sign !== 1'b0) begin
          n_fail++;
          $display("FAIL disp_live cyc=%0d: got %0d sign=%b expected 0 sign=0", k, disp_data, disp_sign);
        end
      end
      if (k == 73) begin
        n_checks++;
        if (disp_data !== 20'd1250) begin
          n_fail++;
          $display("FAIL disp_peak: got %0d expected 1250", disp_data);
        end
      end
      if (k == 72) mode = 1'b1;
      if (k == 73) mode = 1'b0;
    end
    mode = 1'b0;
  endtask

  task automatic test_mid_reset();
    int k;
    fill(255);
    mode = 1'b0; disp_ch = 2'd0;
    do_reset();
    repeat (26) tick();
    n_checks++;
    if (ad_ch !== 2'd2 || res_data !== 20'd4960) begin
      n_fail++;
      $display("FAIL pre_reset: got ch=%0d data=%0d expected ch=2 data=4960", ad_ch, res_data);
    end
    #2;
    sys_rst = 1'b1;
    #1;
    n_checks++;
    if ({ad_clk, ad_ch, volt_valid, res_ch, res_sign, disp_sign} !== 8'd0 || {res_data, disp_data} !== 40'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got ctrl=%b res=%0d disp=%0d expected all 0",
               {ad_clk, ad_ch, volt_valid, res_ch, res_sign, disp_sign}, res_data, disp_data);
    end
    fill(0);
    @(negedge sys_clk);
    ad_data = 8'd0;
    sys_rst = 1'b0;
    repeat (12) begin
      tick();
      k = cyc;
      n_checks++;
      if (volt_valid !== 1'(k == 11)) begin
        n_fail++;
        $display("FAIL restart_valid cyc=%0d: got %b expected %0d", k, volt_valid, (k == 11));
      end
      if (k == 11) begin
        n_checks++;
        if (res_ch !== 2'd0 || res_data !== 20'd5000 || res_sign !== 1'b1) begin
          n_fail++;
          $display("FAIL restart_result: got ch=%0d data=%0d sign=%b expected ch=0 data=5000 sign=1",
                   res_ch, res_data, res_sign);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_constant_codes();
    test_random_scan();
    test_peak_hold();
    test_display();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/volt_scan_meter.md
# volt_scan_meter

Parametrised multi-channel successor to the single-channel voltmeter datapath. Drives the ADC sample clock and the external analog-mux channel select, discards settling samples after each channel switch, averages 2^AVG_LOG2 samples per channel, and converts the result to signed millivolts. It holds per-channel live and peak-magnitude results and presents one selected channel on a display port that feeds the dynamic 7-segment driver (20-bit data plus sign).

## Interface
Parameters:
- AD_WIDTH, 8, ADC code width; offset binary, midscale MID = 2^(AD_WIDTH-1) is 0 V
- CH_NUM, 4, number of multiplexed channels (2..16); CH_W = clog2(CH_NUM)
- AVG_LOG2, 2, log2 of samples averaged per channel (0..6)
- DISCARD, 1, samples dropped after each channel switch (0..3)
- DIV_HALF, 1, sys_clk cycles per ad_clk half period (>= 1)
- FS_MV, 5000, full-scale magnitude in mV at code 0 (max 99999)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- ad_data  in  AD_WIDTH  ADC output code
- mode  in  1  0 = live average, 1 = peak hold
- hold_clr  in  1  one-cycle pulse; clears all peak registers
- disp_ch  in  CH_W  channel routed to the display outputs
- ad_clk  out  1  ADC sample clock
- ad_ch  out  CH_W  analog mux select
- volt_valid  out  1  one-cycle pulse; a new channel result is on res_*
- res_ch  out  CH_W  channel of the current result
- res_data  out  20  result magnitude in mV (live or peak, selected by mode)
- res_sign  out  1  1 = negative
- disp_data  out  20  magnitude for disp_ch, in mV
- disp_sign  out  1  sign for disp_ch

## Operation
- Single clock domain: sys_clk. Asynchronous active-high sys_rst.
- Reset values:
  - all outputs 0; ad_clk low; ad_ch 0
  - div_cnt 0; state SETTLE; accumulators, sample counter, live registers and peak registers all 0
- ad_clk generation:
  - div_cnt is free-running, 0..2*DIV_HALF-1
  - ad_clk = (div_cnt >= DIV_HALF)
  - sample strobe fires in the cycle where div_cnt = 2*DIV_HALF-1; ad_data is registered on that strobe
- Channel FSM; it advances only on strobes:
  - SETTLE: count DISCARD strobes and drop their data, then go to ACCUM. DISCARD = 0 enters ACCUM immediately.
  - ACCUM: acc += ad_data for 2^AVG_LOG2 strobes. acc width is AD_WIDTH+AVG_LOG2, so it cannot overflow.
  - On the final ACCUM strobe:
    - avg = acc >> AVG_LOG2 goes to the calc register; res channel latched
    - acc cleared
    - ad_ch = (ad_ch+1) wraps CH_NUM-1 -> 0
    - FSM returns to SETTLE
- Calc pipeline, independent of the FSM:
  - stage 1: sign = (avg < MID); mag = sign ? MID-avg : avg-MID; mv = (mag*FS_MV) >> (AD_WIDTH-1), truncated. Code 0 gives exactly FS_MV; code MID gives 0 with sign 0.
  - stage 2: write live[ch] = {sign, mv}. Write peak[ch] if mv > peak_mag[ch]; a tie keeps the old value. Drive res_*, pulse volt_valid.
- Reported result: res_* = live value when mode=0, peak value when mode=1. mode is sampled at stage 2; a change mid-scan takes effect on the next result.
- Peak registers update in both modes.
- hold_clr zeroes every peak register (mag and sign). If a stage-2 write hits channel k in the same cycle, clear applies first and peak[k] loads the new value.
- Display: disp_* = registered (mode ? peak[disp_ch] : live[disp_ch]), 1-cycle latency, no update gating.
- Mid-operation reset forces all state to reset values immediately, whatever the pipeline contents; scanning restarts at channel 0 with SETTLE.

## Timing
- Cycle 0 is the first sys_clk edge after sys_rst deasserts. Strobes fall at cycles 2*DIV_HALF*n - 1.
- Per-channel period = (DISCARD + 2^AVG_LOG2) * 2*DIV_HALF sys_clk cycles, with no dead cycles between channels.
- ad_ch changes on the edge after the last ACCUM strobe.
- volt_valid goes high 2 cycles after the last ACCUM strobe of its channel, for exactly 1 cycle. res_* hold until the next volt_valid.
- Defaults:
  - first volt_valid (ch 0) at cycle 11
  - ch 1 result at cycle 21
  - wrap back to ch 0 every 40 cycles
- disp_* follow a disp_ch, mode or register change by 1 cycle.

## Test plan
- Defaults, ad_data = 255 constant -> ch0 volt_valid at cycle 11, res_data = 4960, res_sign 0; ad_ch sequence 0,1,2,3,0.
- ad_data = 0 -> res_data 5000, sign 1. ad_data = 128 -> res_data 0, sign 0.
- Channel-switch stimulus 9 (discarded), then 100, 102, 104, 106 -> avg 103, res_data 976, sign 1.
- mode=1, ch0 scans give 200 then 150:
  - live ch0 results are 2812 then 859
  - peak ch0 holds 2812
  - after hold_clr, next ch0 result reports 859
  - hold_clr coincident with a ch0 write -> peak ch0 = new value
- disp_ch = 2 with distinct per-channel values -> disp_data matches ch2 one cycle after selection. Toggle mode -> disp switches between live and peak in 1 cycle.
- Assert sys_rst mid-ACCUM -> all outputs 0 immediately. After release, first result is ch0 at cycle 11 with no stale accumulation.
